bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Parametrised multi-master bus arbiter/sequencer between the CPU core, OAM/HDMA DMA engines and the shared memory map.
//  Serialises N master requests onto one rd_en/wr_en/addr/data bus, inserts configurable wait states and returns one-cycle acks.
//  Successor to the CPU-only bus drive: any master, any width, any latency.
// PARAMETERS
//  NUM_MASTERS  2   requesting masters, >=1; index 0 = CPU by convention
//  ADDR_W       16  address width
//  DATA_W       8   data width
//  WAIT_STATES  0   extra access cycles beyond the first, 0..15
// PORTS
//  clk        in   1                  clock, all logic on rising edge
//  rst_n      in   1                  synchronous reset, active-low
//  m_req      in   NUM_MASTERS        request, held until matching m_ack
//  m_we       in   NUM_MASTERS        1=write, 0=read; valid with m_req
//  m_addr     in   NUM_MASTERS*ADDR_W packed addresses, master i at [i*ADDR_W +: ADDR_W]
//  m_wdata    in   NUM_MASTERS*DATA_W packed write data
//  m_gnt      out  NUM_MASTERS        one-hot owner, high ACCESS..ACK
//  m_ack      out  NUM_MASTERS        one-cycle completion pulse to owner
//  m_rdata    out  DATA_W             read data, valid in ACK cycle, held until next ACK
//  mem_rd_en  out  1                  memory read strobe
//  mem_wr_en  out  1                  memory write strobe
//  mem_addr   out  ADDR_W             memory address, 0 when not accessing
//  mem_wdata  out  DATA_W             memory write data, 0 when not writing
//  mem_rdata  in   DATA_W             memory read data, same-cycle
//  busy       out  1                  state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; m_gnt, m_ack, m_rdata, mem_*, busy all 0; wait counter 0; RR pointer 0.
//  FSM IDLE -> ACCESS -> ACK -> IDLE.
//  - IDLE: if any m_req, pick winner w, latch m_we/m_addr/m_wdata of w, load cnt=WAIT_STATES, go ACCESS. No req: stay.
//  - ACCESS: m_gnt[w]=1; mem_rd_en=!we, mem_wr_en=we, mem_addr/mem_wdata from latched regs (mem_wdata 0 on reads).
//    Lasts WAIT_STATES+1 cycles; cnt decrements each cycle.
//    At cnt==0: reads capture mem_rdata into m_rdata at that edge; go ACK.
//  - ACK: m_ack[w]=1 exactly one cycle; m_gnt[w] stays 1; mem strobes 0; go IDLE.
//  Per transfer: 1 IDLE + (WAIT_STATES+1) ACCESS + 1 ACK = WAIT_STATES+3 cycles.
//  Requests are sampled only in IDLE. A master still holding m_req in IDLE starts a new transfer.
//  Registered masters drop m_req on the edge that sees m_ack.
//  Latched command is immune to input changes. m_req dropped mid-ACCESS: the transfer still completes and acks.
//  Writes leave m_rdata unchanged.
//  Simultaneous requests: exactly one winner per arbitration; losers wait, m_gnt/m_ack never multi-hot.
//  Master index out of range never granted; NUM_MASTERS=1 degenerates to always-grant 0.
//  Reset mid-operation: abort without ack; strobes low the next cycle.
//  Owner index width = max(1,$clog2(NUM_MASTERS)); RR pointer wraps NUM_MASTERS-1 -> 0.
// CONFIGURATION
//  BUS_ARB_RR_EN defined: round-robin. Search starts at pointer p; after granting w, p <= (w+1) mod NUM_MASTERS.
//  BUS_ARB_RR_EN undefined: fixed priority, lowest index wins (CPU highest). Pointer logic not synthesised.
// TESTING
//  1 Reset: rst_n=0 two cycles with m_req=2'b11 -> all outputs 0, busy=0; release -> grant begins next edge.
//  2 Single read, WAIT_STATES=0: m0 read 0xC000, mem_rdata=0x5A -> rd_en high 1 cycle at addr 0xC000;
//    ack next cycle with m_rdata=0x5A; 3 cycles total.
//  3 Write, WAIT_STATES=2: m1 write 0xFF40<=0x91 -> wr_en high 3 cycles with addr 0xFF40, wdata 0x91; ack after; 5 cycles.
//  4 Contention, fixed priority: m_req=2'b11 held -> m0 served repeatedly, m1 starves.
//    With BUS_ARB_RR_EN: grants alternate 0,1,0,1.
//  5 Abort/robustness: m0 drops req mid-ACCESS -> transfer completes, ack pulses;
//    rst_n=0 in ACCESS -> no ack, strobes 0 next cycle.
//  6 NUM_MASTERS=3, RR: reqs on 1 and 2 after pointer=2 -> grant order 2,1; pointer wraps to 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: serialises N bus masters onto one memory port with configurable wait states and one-cycle acks.
// Define BUS_ARB_RR_EN for round-robin arbitration; undefined gives fixed priority (index 0 highest).
module bus_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_req,
  input  logic [NUM_MASTERS-1:0]        m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_gnt,
  output logic [NUM_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
  logic [NUM_MASTERS-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    rd_en_q, rd_en_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
  logic                    busy_q, busy_d;
`ifdef BUS_ARB_RR_EN
  logic [IDX_W-1:0]        ptr_q, ptr_d;
`endif

  logic                    any_req_c;
  logic [IDX_W-1:0]        win_c;
  logic                    win_we_c;
  logic [ADDR_W-1:0]       win_addr_c;
  logic [DATA_W-1:0]       win_wdata_c;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_MASTERS'(1) << idx;
  endfunction

  // Winner selection among current requests
  always_comb begin
    logic [NUM_MASTERS-1:0] sh;
    any_req_c = 1'b0;
    win_c     = '0;
    sh        = '0;
`ifdef BUS_ARB_RR_EN
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      int unsigned idx;
      idx = int'(ptr_q) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      sh = m_req >> idx;
      if (!any_req_c && sh[0]) begin
        any_req_c = 1'b1;
        win_c     = IDX_W'(idx);
      end
    end
`else
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      sh = m_req >> i;
      if (sh[0]) begin
        any_req_c = 1'b1;
        win_c     = IDX_W'(i);
      end
    end
`endif
  end

  always_comb begin
    logic [NUM_MASTERS-1:0] we_sh;
    we_sh       = m_we >> win_c;
    win_we_c    = we_sh[0];
    win_addr_c  = ADDR_W'(m_addr >> (int'(win_c) * ADDR_W));
    win_wdata_c = DATA_W'(m_wdata >> (int'(win_c) * DATA_W));
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
`ifdef BUS_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (any_req_c) begin
          state_d     = S_ACCESS;
          owner_d     = win_c;
          we_d        = win_we_c;
          addr_d      = win_addr_c;
          wdata_d     = win_wdata_c;
          cnt_d       = CNT_W'(WAIT_STATES);
          gnt_d       = onehot(win_c);
          rd_en_d     = !win_we_c;
          wr_en_d     = win_we_c;
          mem_addr_d  = win_addr_c;
          mem_wdata_d = win_we_c ? win_wdata_c : '0;
`ifdef BUS_ARB_RR_EN
          ptr_d = (int'(win_c) == int'(NUM_MASTERS) - 1) ? '0 : win_c + IDX_W'(1);
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
          ack_d   = onehot(owner_q);
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          cnt_d       = cnt_q - CNT_W'(1);
          rd_en_d     = !we_q;
          wr_en_d     = we_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = we_q ? wdata_q : '0;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
`ifdef BUS_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
`ifdef BUS_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign m_gnt     = gnt_q;
  assign m_ack     = ack_q;
  assign m_rdata   = rdata_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a 2-master zero-wait instance and a 3-master two-wait instance.
// Arbitration expectations follow BUS_ARB_RR_EN when it is defined.
module tb_bus_arbiter;

  localparam int WS_B = 2;

  logic clk;
  logic rst_n;

  logic [1:0]  req_a, we_a, gnt_a, ack_a;
  logic [31:0] addr_a;
  logic [15:0] wdata_a;
  logic [7:0]  rdata_a, mwdata_a, mrdata_a;
  logic [15:0] maddr_a;
  logic        rd_a, wr_a, busy_a;

  logic [2:0]  req_b, we_b, gnt_b, ack_b;
  logic [47:0] addr_b;
  logic [23:0] wdata_b;
  logic [7:0]  rdata_b, mwdata_b, mrdata_b;
  logic [15:0] maddr_b;
  logic        rd_b, wr_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(16), .DATA_W(8), .WAIT_STATES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .m_req(req_a), .m_we(we_a), .m_addr(addr_a), .m_wdata(wdata_a),
    .m_gnt(gnt_a), .m_ack(ack_a), .m_rdata(rdata_a), .mem_rd_en(rd_a), .mem_wr_en(wr_a),
    .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_rdata(mrdata_a), .busy(busy_a)
  );

  bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(8), .WAIT_STATES(WS_B)) u_b (
    .clk(clk), .rst_n(rst_n), .m_req(req_b), .m_we(we_b), .m_addr(addr_b), .m_wdata(wdata_b),
    .m_gnt(gnt_b), .m_ack(ack_b), .m_rdata(rdata_b), .mem_rd_en(rd_b), .mem_wr_en(wr_b),
    .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_rdata(mrdata_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0; mrdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; mrdata_b = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Spec arbitration rule: first requester found searching upward from p (p stays 0 for fixed priority)
  function automatic int pick(input logic [2:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (p + k) % n;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = 2'b11; we_a = '0; addr_a = '0; wdata_a = '0; mrdata_a = 8'hFF;
    req_b = 3'b111; we_b = '0; addr_b = '0; wdata_b = '0; mrdata_b = 8'hFF;
    step();
    step();
    n_checks++;
    if ({gnt_a, ack_a, rdata_a, rd_a, wr_a, maddr_a, mwdata_a, busy_a} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_a: got gnt=%b ack=%b rdata=%h rd=%b wr=%b addr=%h wd=%h busy=%b want all 0",
               gnt_a, ack_a, rdata_a, rd_a, wr_a, maddr_a, mwdata_a, busy_a);
    end
    n_checks++;
    if ({gnt_b, ack_b, rdata_b, rd_b, wr_b, maddr_b, mwdata_b, busy_b} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_b: got gnt=%b ack=%b rdata=%h rd=%b wr=%b addr=%h wd=%h busy=%b want all 0",
               gnt_b, ack_b, rdata_b, rd_b, wr_b, maddr_b, mwdata_b, busy_b);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({gnt_a, busy_a} !== 3'b011) begin
      n_fail++;
      $display("FAIL reset_release_a: got gnt=%b busy=%b want gnt=01 busy=1", gnt_a, busy_a);
    end
    n_checks++;
    if ({gnt_b, busy_b} !== 4'b0011) begin
      n_fail++;
      $display("FAIL reset_release_b: got gnt=%b busy=%b want gnt=001 busy=1", gnt_b, busy_b);
    end
  endtask

  task automatic test_single_read();
    reset_all();
    req_a = 2'b01; we_a = 2'b00; addr_a = {16'h0000, 16'hC000}; mrdata_a = 8'h5A;
    n_checks++;
    if ({rd_a, maddr_a} !== 17'd0) begin
      n_fail++;
      $display("FAIL read_idle: got rd=%b addr=%h want 0/0000", rd_a, maddr_a);
    end
    step();
    n_checks++;
    if ({gnt_a, ack_a, rd_a, wr_a, maddr_a} !== {2'b01, 2'b00, 1'b1, 1'b0, 16'hC000}) begin
      n_fail++;
      $display("FAIL read_access: got gnt=%b ack=%b rd=%b wr=%b addr=%h want 01 00 1 0 c000",
               gnt_a, ack_a, rd_a, wr_a, maddr_a);
    end
    step();
    n_checks++;
    if ({gnt_a, ack_a, rd_a, maddr_a, rdata_a} !== {2'b01, 2'b01, 1'b0, 16'h0000, 8'h5A}) begin
      n_fail++;
      $display("FAIL read_ack: got gnt=%b ack=%b rd=%b addr=%h rdata=%h want 01 01 0 0000 5a",
               gnt_a, ack_a, rd_a, maddr_a, rdata_a);
    end
    req_a = 2'b00;
    mrdata_a = 8'h00;
    step();
    n_checks++;
    if ({gnt_a, ack_a, busy_a, rdata_a} !== {2'b00, 2'b00, 1'b0, 8'h5A}) begin
      n_fail++;
      $display("FAIL read_done: got gnt=%b ack=%b busy=%b rdata=%h want 00 00 0 5a",
               gnt_a, ack_a, busy_a, rdata_a);
    end
  endtask

  task automatic test_write_ws2();
    reset_all();
    req_b = 3'b001; we_b = 3'b000; addr_b = {32'h0, 16'h0100}; mrdata_b = 8'h3C;
    for (int c = 0; c < WS_B + 1; c++) begin
      step();
      n_checks++;
      if ({gnt_b, rd_b, wr_b, maddr_b} !== {3'b001, 1'b1, 1'b0, 16'h0100}) begin
        n_fail++;
        $display("FAIL ws2_read_access%0d: got gnt=%b rd=%b wr=%b addr=%h want 001 1 0 0100",
                 c, gnt_b, rd_b, wr_b, maddr_b);
      end
    end
    step();
    n_checks++;
    if ({ack_b, rdata_b} !== {3'b001, 8'h3C}) begin
      n_fail++;
      $display("FAIL ws2_read_ack: got ack=%b rdata=%h want 001 3c", ack_b, rdata_b);
    end
    req_b = 3'b000;
    step();
    req_b = 3'b010; we_b = 3'b010; addr_b = {16'h0, 16'hFF40, 16'h0}; wdata_b = {8'h0, 8'h91, 8'h0};
    mrdata_b = 8'hEE;
    for (int c = 0; c < WS_B + 1; c++) begin
      step();
      n_checks++;
      if ({gnt_b, ack_b, rd_b, wr_b, maddr_b, mwdata_b} !==
          {3'b010, 3'b000, 1'b0, 1'b1, 16'hFF40, 8'h91}) begin
        n_fail++;
        $display("FAIL ws2_write_access%0d: got gnt=%b ack=%b rd=%b wr=%b addr=%h wd=%h want 010 000 0 1 ff40 91",
                 c, gnt_b, ack_b, rd_b, wr_b, maddr_b, mwdata_b);
      end
      addr_b = {16'h0, 16'h1234, 16'h0};
      wdata_b = {8'h0, 8'h00, 8'h0};
    end
    step();
    n_checks++;
    if ({gnt_b, ack_b, wr_b, maddr_b, mwdata_b, rdata_b} !==
        {3'b010, 3'b010, 1'b0, 16'h0000, 8'h00, 8'h3C}) begin
      n_fail++;
      $display("FAIL ws2_write_ack: got gnt=%b ack=%b wr=%b addr=%h wd=%h rdata=%h want 010 010 0 0000 00 3c",
               gnt_b, ack_b, wr_b, maddr_b, mwdata_b, rdata_b);
    end
    req_b = 3'b000;
    step();
  endtask

  task automatic test_contention();
    int exp_o;
    reset_all();
    req_a = 2'b11; we_a = 2'b00; addr_a = {16'h0020, 16'h0010};
    for (int t = 0; t < 4; t++) begin
`ifdef BUS_ARB_RR_EN
      exp_o = t % 2;
`else
      exp_o = 0;
`endif
      step();
      n_checks++;
      if ({gnt_a, maddr_a} !== {2'(1 << exp_o), (exp_o == 0) ? 16'h0010 : 16'h0020}) begin
        n_fail++;
        $display("FAIL contention_grant%0d: got gnt=%b addr=%h want owner %0d", t, gnt_a, maddr_a, exp_o);
      end
      step();
      n_checks++;
      if (ack_a !== 2'(1 << exp_o)) begin
        n_fail++;
        $display("FAIL contention_ack%0d: got ack=%b want owner %0d", t, ack_a, exp_o);
      end
      step();
      n_checks++;
      if ({gnt_a, ack_a, busy_a} !== 5'd0) begin
        n_fail++;
        $display("FAIL contention_idle%0d: got gnt=%b ack=%b busy=%b want 0", t, gnt_a, ack_a, busy_a);
      end
    end
    req_a = 2'b00;
  endtask

  task automatic test_abort();
    reset_all();
    req_a = 2'b01; we_a = 2'b00; addr_a = {16'h0, 16'h1234}; mrdata_a = 8'hA7;
    step();
    req_a = 2'b00;
    addr_a = {16'h0, 16'h9999};
    step();
    n_checks++;
    if ({ack_a, rdata_a} !== {2'b01, 8'hA7}) begin
      n_fail++;
      $display("FAIL abort_drop_ack: got ack=%b rdata=%h want 01 a7", ack_a, rdata_a);
    end
    step();
    req_a = 2'b10; we_a = 2'b10; addr_a = {16'hABCD, 16'h0}; wdata_a = {8'h77, 8'h0};
    step();
    n_checks++;
    if ({gnt_a, wr_a, maddr_a, mwdata_a} !== {2'b10, 1'b1, 16'hABCD, 8'h77}) begin
      n_fail++;
      $display("FAIL abort_write_access: got gnt=%b wr=%b addr=%h wd=%h want 10 1 abcd 77",
               gnt_a, wr_a, maddr_a, mwdata_a);
    end
    rst_n = 1'b0;
    req_a = 2'b00;
    step();
    n_checks++;
    if ({gnt_a, ack_a, rd_a, wr_a, maddr_a, mwdata_a, busy_a} !== 31'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got gnt=%b ack=%b rd=%b wr=%b addr=%h wd=%h busy=%b want all 0",
               gnt_a, ack_a, rd_a, wr_a, maddr_a, mwdata_a, busy_a);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({ack_a, busy_a} !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_no_ack: got ack=%b busy=%b want 00 0", ack_a, busy_a);
    end
  endtask

  task automatic test_rr_order();
    int order[$];
    int exp_ord[3];
    int cyc;
    reset_all();
`ifdef BUS_ARB_RR_EN
    exp_ord = '{1, 2, 1};
`else
    exp_ord = '{1, 1, 2};
`endif
    we_b = 3'b000; addr_b = {16'h0300, 16'h0200, 16'h0100}; mrdata_b = 8'h11;
    req_b = 3'b010;
    cyc = 0;
    while (order.size() < 3 && cyc < 60) begin
      step();
      cyc++;
      n_checks++;
      if ($countones(gnt_b) > 1 || $countones(ack_b) > 1) begin
        n_fail++;
        $display("FAIL rr_onehot: got gnt=%b ack=%b want at most one bit", gnt_b, ack_b);
      end
      if (ack_b != 3'b000) begin
        for (int i = 0; i < 3; i++) if (ack_b[i]) order.push_back(i);
        req_b = req_b & ~ack_b;
        if (order.size() == 1) req_b = 3'b110;
      end
    end
    n_checks++;
    if (order.size() != 3) begin
      n_fail++;
      $display("FAIL rr_timeout: got %0d acks want 3", order.size());
    end else if (order[0] != exp_ord[0] || order[1] != exp_ord[1] || order[2] != exp_ord[2]) begin
      n_fail++;
      $display("FAIL rr_order: got %0d,%0d,%0d want %0d,%0d,%0d",
               order[0], order[1], order[2], exp_ord[0], exp_ord[1], exp_ord[2]);
    end
    req_b = 3'b000;
    step();
  endtask

  task automatic test_random();
    int pos, w, ptr;
    logic mwe;
    logic [15:0] maddr;
    logic [7:0] mwd, exp_rdata;
    logic acc;
    logic [32:0] exp_v, got_v;
    reset_all();
    pos = 0; w = 0; ptr = 0; mwe = 1'b0; maddr = '0; mwd = '0; exp_rdata = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_b[i] && $urandom_range(0, 3) == 0) begin
          req_b[i] = 1'b1;
          we_b[i] = $urandom_range(0, 1) == 1;
          addr_b[i*16 +: 16] = 16'($urandom);
          wdata_b[i*8 +: 8] = 8'($urandom);
        end else if (req_b[i] && $urandom_range(0, 15) == 0) begin
          req_b[i] = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) addr_b[i*16 +: 16] = 16'($urandom);
        if ($urandom_range(0, 3) == 0) wdata_b[i*8 +: 8] = 8'($urandom);
      end
      mrdata_b = 8'($urandom);
      // Reference timeline: pos 0 idle, 1..WS_B+1 access, WS_B+2 ack
      if (pos == 0) begin
        if (req_b != 3'b000) begin
`ifdef BUS_ARB_RR_EN
          w = pick(req_b, ptr, 3);
          ptr = (w + 1) % 3;
`else
          w = pick(req_b, 0, 3);
`endif
          mwe = we_b[w];
          maddr = addr_b[w*16 +: 16];
          mwd = wdata_b[w*8 +: 8];
          pos = 1;
        end
      end else if (pos <= WS_B + 1) begin
        if (pos == WS_B + 1 && !mwe) exp_rdata = mrdata_b;
        pos++;
      end else begin
        pos = 0;
      end
      step();
      acc = (pos >= 1 && pos <= WS_B + 1);
      exp_v = {(pos != 0) ? 3'(1 << w) : 3'b000,
               (pos == WS_B + 2) ? 3'(1 << w) : 3'b000,
               acc && !mwe, acc && mwe,
               acc ? maddr : 16'h0000,
               (acc && mwe) ? mwd : 8'h00,
               pos != 0};
      got_v = {gnt_b, ack_b, rd_b, wr_b, maddr_b, mwdata_b, busy_b};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_bus cyc %0d: got gnt=%b ack=%b rd=%b wr=%b addr=%h wd=%h busy=%b want %b",
                 cyc, gnt_b, ack_b, rd_b, wr_b, maddr_b, mwdata_b, busy_b, exp_v);
      end
      n_checks++;
      if (rdata_b !== exp_rdata) begin
        n_fail++;
        $display("FAIL random_rdata cyc %0d: got %h want %h", cyc, rdata_b, exp_rdata);
      end
      if (pos == WS_B + 2) req_b[w] = 1'b0;
    end
    req_b = 3'b000;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_ws2();
    test_contention();
    test_abort();
    test_rr_order();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
